// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencing, stall hold, redirect squash, pairs fetch_inst with its PC.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] curr_pc,
  input  logic [31:0] fetch_inst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_valid_q, pend_valid_d;

  always_comb begin
    curr_pc      = pc_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    // Reset shows RESET_PC on the bus so the memory is primed with the boot word.
    if (rst) begin
      curr_pc = RESET_PC;
    end else if (redirect_valid) begin
      curr_pc = redirect_pc;
    end else if (stall) begin
      curr_pc = pend_pc_q;
    end
    if (!rst) begin
      pend_pc_d    = curr_pc;
      pend_valid_d = 1'b1;
      if (redirect_valid || !stall) begin
        pc_d = curr_pc + PC_INC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pend_pc_q    <= RESET_PC;
      pend_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign if_inst  = fetch_inst;
  assign if_pc    = pend_pc_q;
  assign if_valid = pend_valid_q & ~redirect_valid;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stalls_d  = perf_stalls_q;
    if (if_valid && !stall) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (stall && pend_valid_q) begin
      perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= 32'h0;
      perf_stalls_q  <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stalls  = perf_stalls_q;
`else
  assign perf_fetched = 32'h0;
  assign perf_stalls  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential run, stall, redirect, redirect+stall, reset, PC wrap.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] curr_pc, fetch_inst, if_inst, if_pc, perf_fetched, perf_stalls;
  logic        if_valid;

  logic [31:0] w_curr_pc, w_fetch_inst, w_if_inst, w_if_pc, w_perf_fetched, w_perf_stalls;
  logic        w_if_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Memory model: registered read, mem[i] = i.
  always_ff @(posedge clk) begin
    fetch_inst   <= {2'b00, curr_pc[31:2]};
    w_fetch_inst <= {2'b00, w_curr_pc[31:2]};
  end

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .curr_pc(curr_pc), .fetch_inst(fetch_inst),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_inst(if_inst), .if_pc(if_pc), .if_valid(if_valid),
    .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .curr_pc(w_curr_pc), .fetch_inst(w_fetch_inst),
    .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .if_inst(w_if_inst), .if_pc(w_if_pc), .if_valid(w_if_valid),
    .perf_fetched(w_perf_fetched), .perf_stalls(w_perf_stalls)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Drive one cycle's inputs at negedge, then let combinational outputs settle.
  task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] rp);
    @(negedge clk);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    #1;
  endtask

  task automatic out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
    check({tag, ".valid"}, {31'b0, if_valid}, {31'b0, v});
    if (v) begin
      check({tag, ".pc"}, if_pc, pc);
      check({tag, ".inst"}, if_inst, inst);
    end
  endtask

  task automatic perf(input string tag, input logic [31:0] f, input logic [31:0] s);
`ifdef FETCH_PERF_EN
    check({tag, ".fetched"}, perf_fetched, f);
    check({tag, ".stalls"}, perf_stalls, s);
`else
    check({tag, ".fetched"}, perf_fetched, 32'h0);
    check({tag, ".stalls"}, perf_stalls, 32'h0);
`endif
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    // Reset cycle
    cyc(1, 0, 0, 0);
    check("rst.curr_pc", curr_pc, 32'h0);
    out("rst", 0, 0, 0);
    perf("rst.perf", 0, 0);
    check("wrap.rst.curr_pc", w_curr_pc, 32'hFFFF_FFF8);
    // C0: first cycle out of reset, nothing valid yet
    cyc(0, 0, 0, 0);
    check("c0.curr_pc", curr_pc, 32'h0);
    out("c0", 0, 0, 0);
    check("wrap.c0.valid", {31'b0, w_if_valid}, 32'h0);
    // C1..C3 sequential
    cyc(0, 0, 0, 0);
    check("c1.curr_pc", curr_pc, 32'h4);
    out("c1", 1, 32'h0, 32'h0);
    check("wrap.c1.pc", w_if_pc, 32'hFFFF_FFF8);
    check("wrap.c1.inst", w_if_inst, 32'h3FFF_FFFE);
    cyc(0, 0, 0, 0);
    check("c2.curr_pc", curr_pc, 32'h8);
    out("c2", 1, 32'h4, 32'h1);
    check("wrap.c2.pc", w_if_pc, 32'hFFFF_FFFC);
    check("wrap.c2.inst", w_if_inst, 32'h3FFF_FFFF);
    // C3..C5: stall while (8,2) is presented
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      check($sformatf("stall%0d.curr_pc", i), curr_pc, 32'h8);
      out($sformatf("stall%0d", i), 1, 32'h8, 32'h2);
      if (i == 0) begin
        check("wrap.c3.pc", w_if_pc, 32'h0);
        check("wrap.c3.inst", w_if_inst, 32'h0);
        check("wrap.c3.curr_pc", w_curr_pc, 32'h4);
      end
    end
    // C6: release, (8,2) accepted once; C7 follows with no bubble
    cyc(0, 0, 0, 0);
    check("rel.curr_pc", curr_pc, 32'hC);
    out("rel", 1, 32'h8, 32'h2);
    // C7: redirect to 0x40 squashes (12,3)
    cyc(0, 0, 1, 32'h40);
    check("redir.curr_pc", curr_pc, 32'h40);
    check("redir.pc_squashed", if_pc, 32'hC);
    out("redir", 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("c8.curr_pc", curr_pc, 32'h44);
    out("c8", 1, 32'h40, 32'd16);
    cyc(0, 0, 0, 0);
    out("c9", 1, 32'h44, 32'd17);
    // C10: redirect wins over stall
    cyc(0, 1, 1, 32'h80);
    check("rs.curr_pc", curr_pc, 32'h80);
    out("rs", 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("c11.curr_pc", curr_pc, 32'h84);
    out("c11", 1, 32'h80, 32'd32);
    // C12, C13: back-to-back redirects, last wins
    cyc(0, 0, 1, 32'h100);
    out("bb0", 0, 0, 0);
    cyc(0, 0, 1, 32'h200);
    check("bb1.curr_pc", curr_pc, 32'h200);
    out("bb1", 0, 0, 0);
    cyc(0, 0, 0, 0);
    out("c14", 1, 32'h200, 32'd128);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      out($sformatf("c%0d", 15 + i), 1, 32'h204 + 4 * i, 32'd129 + i);
    end
    // C18: accepts C1,C2,C6,C8,C9,C11,C14..C17 = 10; stalls C3,C4,C5,C10 = 4
    cyc(0, 1, 0, 0);
    perf("perf", 32'd10, 32'd4);
    // C19: reset arrives mid-stall
    cyc(1, 1, 0, 0);
    check("rst_stall.curr_pc", curr_pc, 32'h0);
    cyc(0, 0, 0, 0);
    check("post_rst.curr_pc", curr_pc, 32'h0);
    out("post_rst", 0, 0, 0);
    perf("post_rst.perf", 0, 0);
    cyc(0, 0, 0, 0);
    out("post_rst1", 1, 32'h0, 32'h0);
    // Reset during a redirect drops the target
    cyc(1, 0, 1, 32'h300);
    check("rst_redir.curr_pc", curr_pc, 32'h0);
    cyc(0, 0, 0, 0);
    check("post_rst2.curr_pc", curr_pc, 32'h0);
    out("post_rst2", 0, 0, 0);
    cyc(0, 0, 0, 0);
    out("post_rst3", 1, 32'h0, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
